// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - opcode constants and op-class decode shared by the execute stage
package exec_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_LUI  = 6'b110000;
  localparam logic [5:0] OP_ADD  = 6'b001100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUB  = 6'b010100;
  localparam logic [5:0] OP_SLL  = 6'b011100;
  localparam logic [5:0] OP_SLLI = 6'b011000;
  localparam logic [5:0] OP_SRL  = 6'b100100;
  localparam logic [5:0] OP_SRLI = 6'b100000;
  localparam logic [5:0] OP_SRA  = 6'b101100;
  localparam logic [5:0] OP_SRAI = 6'b101000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000110;
  localparam logic [5:0] OP_JR   = 6'b001010;
  localparam logic [5:0] OP_JALR = 6'b001110;
  localparam logic [5:0] OP_BEQ  = 6'b010010;
  localparam logic [5:0] OP_BLE  = 6'b011010;
  localparam logic [5:0] OP_BEQI = 6'b110010;
  localparam logic [5:0] OP_BNEI = 6'b111010;
  localparam logic [5:0] OP_BLEI = 6'b100010;
  localparam logic [5:0] OP_BGEI = 6'b101010;
  localparam logic [5:0] OP_MUL  = 6'b110100;
  localparam logic [5:0] OP_DIV  = 6'b111100;
  localparam logic [5:0] OP_REM  = 6'b111000;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } md_op_t;

  function automatic logic is_alu_op(input logic [5:0] ope);
    case (ope)
      OP_LUI, OP_ADD, OP_ADDI, OP_SUB, OP_SLL, OP_SLLI,
      OP_SRL, OP_SRLI, OP_SRA, OP_SRAI: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic is_link_op(input logic [5:0] ope);
    return (ope == OP_JAL) || (ope == OP_JALR);
  endfunction

  function automatic logic is_branch_op(input logic [5:0] ope);
    case (ope)
      OP_J, OP_JAL, OP_JR, OP_JALR, OP_BEQ, OP_BLE,
      OP_BEQI, OP_BNEI, OP_BLEI, OP_BGEI: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_md_op(input logic [5:0] ope);
    return (ope == OP_MUL) || (ope == OP_DIV) || (ope == OP_REM);
  endfunction

  function automatic md_op_t md_op_of(input logic [5:0] ope);
    case (ope)
      OP_DIV:  return MD_DIV;
      OP_REM:  return MD_REM;
      default: return MD_MUL;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier and restoring divider, one bit per cycle
// Ports: clk/rst (sync, active-high); i_start/i_op/i_a/i_b/i_tag load a new op;
// o_busy high from the load edge until the result edge; o_done pulses one cycle
// with o_result/o_tag valid (both zero otherwise).
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  md_op_t            i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [ADDR_W-1:0] i_tag,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic [ADDR_W-1:0] o_tag
);

  localparam int               CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W);

  logic              r_busy;
  logic              r_done;
  md_op_t            r_op;
  logic [CNT_W-1:0]  r_cnt;
  // r_x: multiplicand for MUL, dividend-in/quotient-out shift register for DIV/REM
  // r_y: multiplier for MUL, divisor magnitude for DIV/REM
  // r_acc: product accumulator for MUL, partial remainder for DIV/REM
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic [DATA_W:0]   r_acc;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_div0;
  logic [ADDR_W-1:0] r_tag;
  logic [DATA_W-1:0] r_result;
  logic [ADDR_W-1:0] r_tag_out;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic [DATA_W:0]   w_rem_shift;
  logic              w_fits;
  logic [DATA_W-1:0] w_acc_lo;
  logic [DATA_W-1:0] w_quot;
  logic [DATA_W-1:0] w_remv;
  logic [DATA_W-1:0] w_final;

  // Division runs on magnitudes; MUL keeps raw bits since the low half of the
  // product is the same for signed and unsigned operands.
  assign w_a_neg     = (i_op != MD_MUL) && i_a[DATA_W-1];
  assign w_b_neg     = (i_op != MD_MUL) && i_b[DATA_W-1];
  assign w_a_mag     = w_a_neg ? -i_a : i_a;
  assign w_b_mag     = w_b_neg ? -i_b : i_b;

  assign w_rem_shift = {r_acc[DATA_W-1:0], r_x[DATA_W-1]};
  assign w_fits      = (w_rem_shift >= {1'b0, r_y});
  assign w_acc_lo    = r_acc[DATA_W-1:0];
  assign w_quot      = r_neg_q ? -r_x : r_x;
  assign w_remv      = r_neg_r ? -w_acc_lo : w_acc_lo;

  // A zero divisor leaves quotient all-ones and remainder |a|; the remainder
  // sign fix already restores a, only the quotient needs forcing to all-ones.
  always_comb begin
    w_final = w_acc_lo;
    case (r_op)
      MD_DIV:  w_final = r_div0 ? '1 : w_quot;
      MD_REM:  w_final = w_remv;
      default: w_final = w_acc_lo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_op      <= MD_MUL;
      r_cnt     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
      r_tag     <= '0;
      r_result  <= '0;
      r_tag_out <= '0;
    end else begin
      r_done    <= 1'b0;
      r_result  <= '0;
      r_tag_out <= '0;
      if (i_start && !r_busy) begin
        r_busy  <= 1'b1;
        r_op    <= i_op;
        r_cnt   <= '0;
        r_acc   <= '0;
        r_x     <= w_a_mag;
        r_y     <= w_b_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_div0  <= (i_b == '0);
        r_tag   <= i_tag;
      end else if (r_busy) begin
        if (r_cnt == LAST) begin
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_result  <= w_final;
          r_tag_out <= r_tag;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op == MD_MUL) begin
            if (r_y[0]) begin
              r_acc <= {1'b0, w_acc_lo + r_x};
            end
            r_x <= r_x << 1;
            r_y <= r_y >> 1;
          end else begin
            r_acc <= w_fits ? (w_rem_shift - {1'b0, r_y}) : w_rem_shift;
            r_x   <= {r_x[DATA_W-2:0], w_fits};
          end
        end
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_tag    = r_tag_out;

endmodule

// File: rtl/alu_branch_unit.sv
// rtl/alu_branch_unit.sv - single-issue ALU, branch resolution and mul/div execute unit
// Ports: clk/rst (sync, active-high); in_valid/in_ready issue handshake with
// pc, ope, ds_val, dt_val, dd, imm, opr, pred_taken; alu_* 1-cycle ALU/link
// result; md_* mul/div result; b_* branch resolution; busy while mul/div runs.
module alu_branch_unit
  import exec_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 14,
  parameter int ADDR_W    = 6,
  parameter int LINK_ADDR = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc,
  input  logic [5:0]        ope,
  input  logic [DATA_W-1:0] ds_val,
  input  logic [DATA_W-1:0] dt_val,
  input  logic [ADDR_W-1:0] dd,
  input  logic [15:0]       imm,
  input  logic [4:0]        opr,
  input  logic              pred_taken,
  output logic              alu_valid,
  output logic [ADDR_W-1:0] alu_addr,
  output logic [DATA_W-1:0] alu_dd_val,
  output logic              md_valid,
  output logic [ADDR_W-1:0] md_addr,
  output logic [DATA_W-1:0] md_dd_val,
  output logic              b_valid,
  output logic              b_is_hazard,
  output logic [PC_W-1:0]   b_addr,
  output logic              b_is_b_ope,
  output logic              b_is_branch,
  output logic [PC_W-1:0]   b_w_pc,
  output logic              busy
);

  localparam int SH_W = $clog2(DATA_W);

  logic              w_md_busy;
  logic              w_accept;
  logic              w_alu_wr;
  logic              w_link;
  logic              w_br;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_opr_sext;
  logic [DATA_W-1:0] w_opb;
  logic [SH_W-1:0]   w_shamt;
  logic [DATA_W-1:0] w_alu_res;
  logic [PC_W-1:0]   w_pc_inc;
  logic              w_taken;
  logic              w_is_b_ope;
  logic              w_is_jr;
  logic [PC_W-1:0]   w_b_target;
  logic              w_hazard;

  logic              r_alu_valid;
  logic [ADDR_W-1:0] r_alu_addr;
  logic [DATA_W-1:0] r_alu_dd_val;
  logic              r_b_valid;
  logic              r_b_is_hazard;
  logic [PC_W-1:0]   r_b_addr;
  logic              r_b_is_b_ope;
  logic              r_b_is_branch;
  logic [PC_W-1:0]   r_b_w_pc;

  assign w_accept   = in_valid & ~w_md_busy;
  assign w_link     = is_link_op(ope);
  assign w_alu_wr   = w_accept & (is_alu_op(ope) | w_link);
  assign w_br       = w_accept & is_branch_op(ope);

  assign w_imm_sext = DATA_W'($signed(imm));
  assign w_opr_sext = DATA_W'($signed(opr));
  // ope[2] separates register-register forms from their immediate twins
  assign w_opb      = ope[2] ? dt_val : w_imm_sext;
  assign w_shamt    = w_opb[SH_W-1:0];
  assign w_pc_inc   = pc + PC_W'(1);

  always_comb begin
    w_alu_res = '0;
    case (ope)
      OP_LUI:           w_alu_res = DATA_W'({imm, ds_val[15:0]});
      OP_ADD, OP_ADDI:  w_alu_res = ds_val + w_opb;
      OP_SUB:           w_alu_res = ds_val - w_opb;
      OP_SLL, OP_SLLI:  w_alu_res = ds_val << w_shamt;
      OP_SRL, OP_SRLI:  w_alu_res = ds_val >> w_shamt;
      OP_SRA, OP_SRAI:  w_alu_res = $signed(ds_val) >>> w_shamt;
      default:          w_alu_res = '0;
    endcase
  end

  // Unconditional jumps always count as taken.
  always_comb begin
    w_taken = 1'b0;
    case (ope)
      OP_J, OP_JAL, OP_JR, OP_JALR: w_taken = 1'b1;
      OP_BEQ:  w_taken = (ds_val == dt_val);
      OP_BLE:  w_taken = ($signed(ds_val) <= $signed(dt_val));
      OP_BEQI: w_taken = (ds_val == w_opr_sext);
      OP_BNEI: w_taken = (ds_val != w_opr_sext);
      OP_BLEI: w_taken = ($signed(ds_val) <= $signed(w_opr_sext));
      OP_BGEI: w_taken = ($signed(ds_val) >= $signed(w_opr_sext));
      default: w_taken = 1'b0;
    endcase
  end

  assign w_is_b_ope = (ope[5:4] != 2'b00);
  assign w_is_jr    = (ope == OP_JR) || (ope == OP_JALR);
  // Jumps redirect to ds; conditional branches to imm when taken, else fall through.
  assign w_b_target = !w_is_b_ope ? ds_val[PC_W-1:0]
                    : (w_taken ? imm[PC_W-1:0] : w_pc_inc);
  // Fetch already followed J/JAL; register jumps and mispredicts need a redirect.
  assign w_hazard   = w_is_jr | (w_is_b_ope & (w_taken ^ pred_taken));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_valid   <= 1'b0;
      r_alu_addr    <= '0;
      r_alu_dd_val  <= '0;
      r_b_valid     <= 1'b0;
      r_b_is_hazard <= 1'b0;
      r_b_addr      <= '0;
      r_b_is_b_ope  <= 1'b0;
      r_b_is_branch <= 1'b0;
      r_b_w_pc      <= '0;
    end else begin
      r_alu_valid   <= w_alu_wr;
      r_alu_addr    <= !w_alu_wr ? '0 : (w_link ? ADDR_W'(LINK_ADDR) : dd);
      r_alu_dd_val  <= !w_alu_wr ? '0 : (w_link ? DATA_W'(w_pc_inc) : w_alu_res);
      r_b_valid     <= w_br;
      r_b_is_hazard <= w_br & w_hazard;
      r_b_addr      <= w_br ? w_b_target : '0;
      r_b_is_b_ope  <= w_br & w_is_b_ope;
      r_b_is_branch <= w_br & w_taken;
      r_b_w_pc      <= w_br ? pc : '0;
    end
  end

  muldiv_iter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept & is_md_op(ope)),
    .i_op     (md_op_of(ope)),
    .i_a      (ds_val),
    .i_b      (dt_val),
    .i_tag    (dd),
    .o_busy   (w_md_busy),
    .o_done   (md_valid),
    .o_result (md_dd_val),
    .o_tag    (md_addr)
  );

  assign busy        = w_md_busy;
  assign in_ready    = ~w_md_busy;
  assign alu_valid   = r_alu_valid;
  assign alu_addr    = r_alu_addr;
  assign alu_dd_val  = r_alu_dd_val;
  assign b_valid     = r_b_valid;
  assign b_is_hazard = r_b_is_hazard;
  assign b_addr      = r_b_addr;
  assign b_is_b_ope  = r_b_is_b_ope;
  assign b_is_branch = r_b_is_branch;
  assign b_w_pc      = r_b_w_pc;

endmodule
